// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared definitions for the DDS sweep controller: state encoding and default widths.
package dds_sweep_ctrl_pkg;

    localparam int ADDRESS_WIDTH_DEF = 8;
    localparam int DWELL_WIDTH_DEF   = 16;
    localparam int INITIAL_STEP_DEF  = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_DWELL     = 3'd2,
        ST_WAIT_ZERO = 3'd3,
        ST_DONE      = 3'd4
    } sweep_state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; last is high while the count equals 1.
module dds_dwell_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == WIDTH'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving a DDS step_in/SET pair.
// Define DDS_SWEEP_ZERO_SYNC_EN to hold each step change until the DDS reports phase zero.
module dds_sweep_ctrl
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int DWELL_WIDTH   = DWELL_WIDTH_DEF,
    parameter int INITIAL_STEP  = INITIAL_STEP_DEF
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH-1:0] start_step,
    input  logic [ADDRESS_WIDTH-1:0] stop_step,
    input  logic [ADDRESS_WIDTH-1:0] step_inc,
    input  logic [DWELL_WIDTH-1:0]   dwell_cycles,
    input  logic                     zero_address,
    output logic                     SET,
    output logic [ADDRESS_WIDTH-1:0] step_out,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               state_dbg
);

    sweep_state_e state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cur_q, cur_d;
    logic [ADDRESS_WIDTH-1:0] out_q, out_d;
    logic [ADDRESS_WIDTH-1:0] stop_q, stop_d;
    logic [ADDRESS_WIDTH-1:0] inc_q, inc_d;
    logic [DWELL_WIDTH-1:0]   dwell_q, dwell_d;
    logic [ADDRESS_WIDTH:0]   nxt;
    logic                     end_sweep;
    logic                     timer_clr, timer_load, timer_dec, timer_last;
    logic [DWELL_WIDTH-1:0]   dwell_load;

`ifndef DDS_SWEEP_ZERO_SYNC_EN
    logic unused_zero_address;
    assign unused_zero_address = zero_address;
`endif

    // One extra bit so a wrap past the top of the step range ends the sweep.
    assign nxt        = {1'b0, cur_q} + {1'b0, inc_q};
    assign end_sweep  = (inc_q == '0) || nxt[ADDRESS_WIDTH] || (nxt[ADDRESS_WIDTH-1:0] > stop_q);
    assign dwell_load = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        out_d      = out_q;
        stop_d     = stop_q;
        inc_d      = inc_q;
        dwell_d    = dwell_q;
        timer_clr  = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            timer_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        cur_d   = start_step;
                        out_d   = start_step;
                        stop_d  = stop_step;
                        inc_d   = step_inc;
                        dwell_d = dwell_cycles;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    timer_load = 1'b1;
                    state_d    = ST_DWELL;
                end
                ST_DWELL: begin
                    timer_dec = 1'b1;
                    if (timer_last) begin
                        if (end_sweep) begin
                            state_d = ST_DONE;
                        end else begin
                            cur_d = nxt[ADDRESS_WIDTH-1:0];
`ifdef DDS_SWEEP_ZERO_SYNC_EN
                            state_d = ST_WAIT_ZERO;
`else
                            out_d   = nxt[ADDRESS_WIDTH-1:0];
                            state_d = ST_LOAD;
`endif
                        end
                    end
                end
`ifdef DDS_SWEEP_ZERO_SYNC_EN
                ST_WAIT_ZERO: begin
                    if (zero_address) begin
                        out_d   = cur_q;
                        state_d = ST_LOAD;
                    end
                end
`endif
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            out_q   <= ADDRESS_WIDTH'(INITIAL_STEP);
            stop_q  <= '0;
            inc_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            out_q   <= out_d;
            stop_q  <= stop_d;
            inc_q   <= inc_d;
            dwell_q <= dwell_d;
        end
    end

    dds_dwell_timer #(
        .WIDTH(DWELL_WIDTH)
    ) u_dwell_timer (
        .clk      (CLK),
        .rst_n    (RESET),
        .clr      (timer_clr),
        .load     (timer_load),
        .load_val (dwell_load),
        .dec      (timer_dec),
        .last     (timer_last)
    );

    assign SET       = (state_q == ST_LOAD);
    assign step_out  = out_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl with a simple DDS phase model feeding zero_address.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int BUDGET = 6000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [AW-1:0] start_step, stop_step, step_inc;
    logic [DW-1:0] dwell_cycles;
    logic          zero_address;
    logic          set;
    logic [AW-1:0] step_out;
    logic          busy, done;
    logic [2:0]    state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [AW-1:0] exp_q[$];

    always #5 clk = ~clk;

    dds_sweep_ctrl #(
        .ADDRESS_WIDTH (AW),
        .DWELL_WIDTH   (DW),
        .INITIAL_STEP  (1)
    ) dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .start        (start),
        .abort        (abort),
        .start_step   (start_step),
        .stop_step    (stop_step),
        .step_inc     (step_inc),
        .dwell_cycles (dwell_cycles),
        .zero_address (zero_address),
        .SET          (set),
        .step_out     (step_out),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    // DDS model: a load restarts the phase at 0, then it advances by the loaded step.
    logic [AW-1:0] dds_phase, dds_step;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dds_phase <= '0;
            dds_step  <= AW'(1);
        end else if (set) begin
            dds_phase <= '0;
            dds_step  <= step_out;
        end else begin
            dds_phase <= dds_phase + dds_step;
        end
    end
    assign zero_address = (dds_phase == '0);

    task automatic build_model(input int st, input int sp, input int inc);
        int s;
        exp_q.delete();
        s = st;
        exp_q.push_back(AW'(st));
        if (inc != 0) begin
            while (s + inc <= sp) begin
                s = s + inc;
                exp_q.push_back(AW'(s));
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        tests_run++;
        if (set !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state_dbg !== 3'd0) begin
            tests_failed++;
            $display("FAIL %s: set=%b busy=%b done=%b state=%0d, required 0 0 0 0",
                     name, set, busy, done, state_dbg);
        end
    endtask

    task automatic run_sweep(input int st, input int sp, input int inc, input int dw, input string name);
        int d, idx, set_k_last, done_k, done_cnt;
        logic prev_zero;
        logic [AW-1:0] exp_v;
        bit finished;
        d = (dw == 0) ? 1 : dw;
        build_model(st, sp, inc);
        @(negedge clk);
        start_step   = AW'(st);
        stop_step    = AW'(sp);
        step_inc     = AW'(inc);
        dwell_cycles = DW'(dw);
        start        = 1'b1;
        prev_zero    = 1'b0;
        idx          = 0;
        done_k       = -1;
        done_cnt     = 0;
        set_k_last   = -1;
        finished     = 1'b0;
        for (int k = 1; k <= BUDGET && !finished; k++) begin
            @(negedge clk);
            if (set) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s extra_set: cycle %0d step_out=%0d, required no SET", name, k, step_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (step_out !== exp_v) begin
                        tests_failed++;
                        $display("FAIL %s step_value[%0d]: got %0d required %0d", name, idx, step_out, exp_v);
                    end
                end
                tests_run++;
`ifdef DDS_SWEEP_ZERO_SYNC_EN
                if ((idx == 0) ? (k != 1) : (prev_zero !== 1'b1 || k < 1 + idx * (1 + d))) begin
                    tests_failed++;
                    $display("FAIL %s set_timing[%0d]: cycle %0d prev_zero=%b, required zero seen the cycle before",
                             name, idx, k, prev_zero);
                end
`else
                if (k != 1 + idx * (1 + d)) begin
                    tests_failed++;
                    $display("FAIL %s set_timing[%0d]: cycle %0d required %0d", name, idx, k, 1 + idx * (1 + d));
                end
`endif
                idx++;
                set_k_last = k;
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            tests_run++;
            if (done_k > 0 && k == done_k + 1) begin
                finished = 1'b1;
                if (busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s busy_after_done: got %b required 0", name, busy);
                end
            end else if (busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s busy_during: cycle %0d got %b required 1", name, k, busy);
            end
            prev_zero = zero_address;
            if (k == 1) begin
                start        = 1'b0;
                start_step   = AW'($urandom_range(0, 255));
                stop_step    = AW'($urandom_range(0, 255));
                step_inc     = AW'($urandom_range(0, 255));
                dwell_cycles = DW'($urandom_range(0, 9));
            end
            if (k == 3) start = 1'b1;
            if (k == 4) start = 1'b0;
        end
        start = 1'b0;
        tests_run++;
        if (!finished) begin
            tests_failed++;
            $display("FAIL %s timeout: no completion within %0d cycles", name, BUDGET);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s missing_sets: %0d steps not issued, required 0", name, exp_q.size());
        end
        tests_run++;
        if (done_cnt != 1 || done_k != set_k_last + 1 + d) begin
            tests_failed++;
            $display("FAIL %s done_timing: count %0d at cycle %0d, required 1 at cycle %0d",
                     name, done_cnt, done_k, set_k_last + 1 + d);
        end
    endtask

    task automatic test_reset;
        tests_run++;
        if (set !== 1'b0 || step_out !== AW'(1) || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: set=%b step_out=%0d busy=%b done=%b, required 0 1 0 0", set, step_out, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_release");
        tests_run++;
        if (step_out !== AW'(1)) begin
            tests_failed++;
            $display("FAIL reset_step_out: got %0d required 1", step_out);
        end
    endtask

    task automatic test_fixed_sweeps;
        run_sweep(10, 30, 10, 4, "basic");
        run_sweep(10, 25, 10, 2, "overshoot");
        run_sweep(250, 255, 4, 1, "carry");
        run_sweep(50, 200, 0, 0, "inc_zero");
        run_sweep(40, 20, 5, 3, "start_gt_stop");
        run_sweep(0, 10, 5, 2, "zero_step");
        run_sweep(255, 255, 1, 1, "top_edge");
    endtask

    task automatic test_random;
        int st, sp, inc, dw;
        for (int i = 0; i < 8; i++) begin
            st  = $urandom_range(0, 255);
            sp  = $urandom_range(0, 255);
            inc = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(16, 80);
            dw  = $urandom_range(0, 6);
            run_sweep(st, sp, inc, dw, "random");
        end
    endtask

    task automatic test_abort;
        bit found;
        int extra_done, extra_set;
        found = 1'b0;
        @(negedge clk);
        start_step   = 8'd10;
        stop_step    = 8'd30;
        step_inc     = 8'd10;
        dwell_cycles = 16'd4;
        start        = 1'b1;
        for (int k = 0; k < BUDGET && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (set && step_out == 8'd20) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL abort_reach_step: step 20 not issued within %0d cycles", BUDGET);
        end
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outputs("abort_idle");
        tests_run++;
        if (step_out !== 8'd20) begin
            tests_failed++;
            $display("FAIL abort_step_hold: got %0d required 20", step_out);
        end
        extra_done = 0;
        extra_set  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (set) extra_set++;
        end
        tests_run++;
        if (extra_done != 0 || extra_set != 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: done %0d set %0d, required 0 0", extra_done, extra_set);
        end
        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_idle_outputs("abort_wins_start");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start_step   = 8'd10;
        stop_step    = 8'd200;
        step_inc     = 8'd10;
        dwell_cycles = 16'd3;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (set !== 1'b0 || step_out !== AW'(1) || busy !== 1'b0 || done !== 1'b0 || state_dbg !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: set=%b step_out=%0d busy=%b done=%b state=%0d, required 0 1 0 0 0",
                     set, step_out, busy, done, state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset_mid_release");
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        start_step   = '0;
        stop_step    = '0;
        step_inc     = '0;
        dwell_cycles = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_fixed_sweeps();
        test_random();
        test_abort();
        test_reset_mid();
        run_sweep(10, 30, 10, 4, "after_reset");
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
